// File: rtl/sort_frame_loader.sv
// Serial-to-parallel frame loader feeding the registered sorting network: packs
// NUM_INPUTS samples with positional index tags, then holds the frame for PIPE_DEPTH cycles.
module sort_frame_loader #(
   parameter int NUM_INPUTS    = 8,
   parameter int PIPE_DEPTH    = 6,
   parameter int NETWORK_WIDTH = 16,
   parameter int INDEX_WIDTH   = 3
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic [NETWORK_WIDTH-1:0]            in_data,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic                                flush,
   output logic [NUM_INPUTS*NETWORK_WIDTH-1:0] net_data,
   output logic [NUM_INPUTS*INDEX_WIDTH-1:0]   net_index,
   output logic                                net_ready,
   output logic                                frame_done,
   output logic [15:0]                         frames_out
);

   localparam int SLOT_W = $clog2(NUM_INPUTS);
   localparam int HOLD_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

   generate
      if (INDEX_WIDTH < SLOT_W) begin : g_bad_index
         $error("INDEX_WIDTH too small to tag every slot");
      end
      if (PIPE_DEPTH < 1) begin : g_bad_depth
         $error("PIPE_DEPTH must be at least 1");
      end
   endgenerate

   typedef enum logic {FILL, HOLD} state_t;

   state_t                              state_q;
   logic [SLOT_W-1:0]                   slot_q;
   logic [HOLD_W-1:0]                   hold_q;
   logic [NUM_INPUTS*NETWORK_WIDTH-1:0] data_q;
   logic [NUM_INPUTS*INDEX_WIDTH-1:0]   index_q;
   logic                                ready_q;
   logic                                done_q;
   logic [15:0]                         frames_q;

   logic [SLOT_W-1:0] slot_d;
   logic [HOLD_W-1:0] hold_d;
   logic [15:0]       frames_d;
   logic              last_slot;
   logic              last_hold;

   assign slot_d    = slot_q + 1'b1;
   assign hold_d    = hold_q + 1'b1;
   assign frames_d  = frames_q + 16'd1;
   assign last_slot = (slot_q == SLOT_W'(NUM_INPUTS - 1));
   assign last_hold = (hold_q == HOLD_W'(PIPE_DEPTH - 1));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= FILL;
         slot_q   <= '0;
         hold_q   <= '0;
         data_q   <= '0;
         index_q  <= '0;
         ready_q  <= 1'b0;
         done_q   <= 1'b0;
         frames_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            FILL: begin
               // flush outranks a transfer, including the one that would launch
               if (flush) begin
                  slot_q <= '0;
               end else if (in_valid) begin
                  for (int k = 0; k < NUM_INPUTS; k++) begin
                     if (slot_q == SLOT_W'(k)) begin
                        data_q[k*NETWORK_WIDTH +: NETWORK_WIDTH] <= in_data;
                        index_q[k*INDEX_WIDTH +: INDEX_WIDTH]    <= INDEX_WIDTH'(k);
                     end
                  end
                  if (last_slot) begin
                     slot_q  <= '0;
                     hold_q  <= '0;
                     ready_q <= 1'b1;
                     state_q <= HOLD;
                  end else begin
                     slot_q <= slot_d;
                  end
               end
            end
            HOLD: begin
               if (last_hold) begin
                  hold_q   <= '0;
                  ready_q  <= 1'b0;
                  done_q   <= 1'b1;
                  frames_q <= frames_d;
                  state_q  <= FILL;
               end else begin
                  hold_q <= hold_d;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

   assign in_ready   = (state_q == FILL);
   assign net_data   = data_q;
   assign net_index  = index_q;
   assign net_ready  = ready_q;
   assign frame_done = done_q;
   assign frames_out = frames_q;

endmodule
